// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: pending/enable registers, lowest-index claim, ID-matched complete.
// Optional macro IRQ_CTRL_SYNC_EN inserts a 2-flop synchroniser ahead of edge detection.
module irq_ctrl #(
    parameter int unsigned NUM_SRC = 8,
    parameter int unsigned ID_W    = 5
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_SRC-1:0] irq_src_i,
    input  logic               irq_ack_i,
    output logic               meip_o,
    input  logic               wr_en_i,
    input  logic [1:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    output logic [ID_W-1:0]    claim_id_o
);

    typedef enum logic [1:0] {
        REG_ENABLE   = 2'd0,
        REG_PENDING  = 2'd1,
        REG_CLAIM    = 2'd2,
        REG_COMPLETE = 2'd3
    } reg_sel_e;

    reg_sel_e           sel;
    logic [NUM_SRC-1:0] src_seen;
    logic [NUM_SRC-1:0] src_q;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] enable;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] edges;
    logic [NUM_SRC-1:0] claim_mask;
    logic [NUM_SRC-1:0] w1c_mask;
    logic [NUM_SRC-1:0] clr_mask;
    logic [ID_W-1:0]    sel_id;
    logic               in_service;
    logic               any_active;
    logic               complete_wr;
    logic               complete_hit;
    logic               ack_take;
    logic               unused_wdata;

    assign sel = reg_sel_e'(addr_i);

`ifdef IRQ_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q;
    logic [NUM_SRC-1:0] sync2_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src_i;
            sync2_q <= sync1_q;
        end
    end

    assign src_seen = sync2_q;
`else
    assign src_seen = irq_src_i;
`endif

    assign edges      = src_seen & ~src_q;
    assign active     = pending & enable;
    assign any_active = |active;
    assign meip_o     = any_active & ~in_service;

    // A COMPLETE write always swallows a same-cycle ack, matched or not.
    assign complete_wr  = wr_en_i && (sel == REG_COMPLETE);
    assign complete_hit = complete_wr && in_service && (wdata_i[ID_W-1:0] == claim_id_o);
    assign ack_take     = irq_ack_i && !in_service && !complete_wr;

    assign w1c_mask = (wr_en_i && (sel == REG_PENDING)) ? wdata_i[NUM_SRC-1:0] : '0;
    assign clr_mask = w1c_mask | (ack_take ? claim_mask : '0);

    assign unused_wdata = ^wdata_i[31:NUM_SRC];

    // Descending scan: the last hit written is the lowest active index.
    always_comb begin
        sel_id     = '0;
        claim_mask = '0;
        for (int unsigned k = NUM_SRC; k > 0; k--) begin
            if (active[k-1]) begin
                sel_id          = ID_W'(k);
                claim_mask      = '0;
                claim_mask[k-1] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            src_q      <= '0;
            pending    <= '0;
            enable     <= '0;
            in_service <= 1'b0;
            claim_id_o <= '0;
            rdata_o    <= '0;
        end else begin
            src_q   <= src_seen;
            // Set wins over a same-cycle claim or write-1-to-clear.
            pending <= (pending & ~clr_mask) | edges;

            if (wr_en_i && (sel == REG_ENABLE)) begin
                enable <= wdata_i[NUM_SRC-1:0];
            end

            if (complete_hit) begin
                in_service <= 1'b0;
                claim_id_o <= '0;
            end else if (ack_take) begin
                if (any_active) begin
                    claim_id_o <= sel_id;
                    in_service <= 1'b1;
                end else begin
                    claim_id_o <= '0;
                end
            end

            unique case (sel)
                REG_ENABLE:   rdata_o <= 32'(enable);
                REG_PENDING:  rdata_o <= 32'(pending);
                REG_CLAIM:    rdata_o <= 32'(claim_id_o);
                REG_COMPLETE: rdata_o <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: a behavioural model predicts meip/claim/rdata each cycle,
// a monitor compares them after every rising edge; directed scenarios add constant checks.
module tb_irq_ctrl;
    localparam int NUM  = 8;
    localparam int IDW  = 5;
    localparam int FULL = (1 << NUM) - 1;
`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic            clk_i = 1'b0;
    logic            reset_i = 1'b1;
    logic [NUM-1:0]  irq_src_i = '0;
    logic            irq_ack_i = 1'b0;
    logic            meip_o;
    logic            wr_en_i = 1'b0;
    logic [1:0]      addr_i = '0;
    logic [31:0]     wdata_i = '0;
    logic [31:0]     rdata_o;
    logic [IDW-1:0]  claim_id_o;

    irq_ctrl #(.NUM_SRC(NUM), .ID_W(IDW)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .irq_src_i  (irq_src_i),
        .irq_ack_i  (irq_ack_i),
        .meip_o     (meip_o),
        .wr_en_i    (wr_en_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .rdata_o    (rdata_o),
        .claim_id_o (claim_id_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic           meip;
        logic [IDW-1:0] claim;
        logic [31:0]    rdata;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference state, kept as plain integer bitmasks.
    int m_en = 0, m_pend = 0, m_srcq = 0, m_claim = 0;
    bit m_insvc = 1'b0;
`ifdef IRQ_CTRL_SYNC_EN
    int m_s1 = 0, m_s2 = 0;
`endif

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Drive one cycle of inputs and predict the outputs after the coming rising edge.
    task automatic cyc(input bit rst, input bit ack, input bit wr, input int a, input int wd, input int src);
        exp_t e;
        int seen, edges, pe, clr, rd, k;
        @(negedge clk_i);
        reset_i   = rst;
        irq_ack_i = ack;
        wr_en_i   = wr;
        addr_i    = a[1:0];
        wdata_i   = wd;
        irq_src_i = src[NUM-1:0];
        if (rst) begin
            m_en = 0; m_pend = 0; m_srcq = 0; m_claim = 0; m_insvc = 1'b0;
`ifdef IRQ_CTRL_SYNC_EN
            m_s1 = 0; m_s2 = 0;
`endif
            e = '0;
        end else begin
            case (a)
                0: rd = m_en;
                1: rd = m_pend;
                2: rd = m_claim;
                default: rd = 0;
            endcase
`ifdef IRQ_CTRL_SYNC_EN
            seen = m_s2;
            m_s2 = m_s1;
            m_s1 = src & FULL;
`else
            seen = src & FULL;
`endif
            edges = seen & ~m_srcq;
            pe    = m_pend & m_en;
            clr   = (wr && a == 1) ? (wd & FULL) : 0;
            if (wr && a == 3 && m_insvc && ((wd & ((1 << IDW) - 1)) == m_claim)) begin
                m_insvc = 1'b0;
                m_claim = 0;
            end else if (ack && !m_insvc && !(wr && a == 3)) begin
                if (pe != 0) begin
                    k = 0;
                    while (pe[k] == 1'b0) k++;
                    m_claim = k + 1;
                    clr     = clr | (1 << k);
                    m_insvc = 1'b1;
                end else begin
                    m_claim = 0;
                end
            end
            m_pend = (m_pend & ~clr) | edges;
            if (wr && a == 0) m_en = wd & FULL;
            m_srcq  = seen;
            e.meip  = ((m_pend & m_en) != 0) && !m_insvc;
            e.claim = m_claim[IDW-1:0];
            e.rdata = rd;
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every rising edge presents a new output sample.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests++;
                if ({meip_o, claim_id_o, rdata_o} !== e) begin
                    fails++;
                    $display("FAIL sb t=%0t: got meip=%0b claim=%0d rdata=%h expected meip=%0b claim=%0d rdata=%h",
                             $time, meip_o, claim_id_o, rdata_o, e.meip, e.claim, e.rdata);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int src_lvl, ack, wr, a, wd;
        bit rst;

        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        idle(1);
        chk("rst_meip", meip_o, 0);
        chk("rst_claim", claim_id_o, 0);
        chk("rst_rdata", rdata_o, 0);

        // Single source through claim.
        cyc(0, 0, 1, 0, 'h01, 0);
        cyc(0, 0, 0, 0, 0, 'h01);
        idle(LAT - 1);
        chk("lat_early", meip_o, 0);
        idle(1);
        chk("single_meip", meip_o, 1);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 1, 0, 0);
        chk("single_pend", rdata_o, 'h01);
        cyc(0, 0, 0, 1, 0, 0);
        chk("single_claim", claim_id_o, 1);
        chk("single_meip_svc", meip_o, 0);
        idle(1);
        chk("single_pend_clr", rdata_o, 0);
        cyc(0, 0, 1, 3, 1, 0);

        // Two simultaneous sources: lowest first.
        cyc(0, 0, 1, 0, 'hFF, 0);
        cyc(0, 0, 0, 0, 0, 'h24);
        idle(LAT);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("prio_claim_lo", claim_id_o, 3);
        cyc(0, 0, 1, 3, 3, 0);
        idle(1);
        chk("prio_meip_after", meip_o, 1);
        chk("prio_claim_clr", claim_id_o, 0);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("prio_claim_hi", claim_id_o, 6);
        cyc(0, 0, 1, 3, 6, 0);

        // Pending while disabled.
        cyc(0, 0, 1, 0, 'h00, 0);
        cyc(0, 0, 0, 0, 0, 'h10);
        idle(LAT);
        cyc(0, 0, 0, 1, 0, 0);
        idle(1);
        chk("dis_pend", rdata_o, 'h10);
        chk("dis_meip", meip_o, 0);
        cyc(0, 0, 1, 0, 'h10, 0);
        idle(1);
        chk("en_meip", meip_o, 1);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 3, 5, 0);

        // Mismatched complete is ignored.
        cyc(0, 0, 1, 0, 'h01, 0);
        cyc(0, 0, 0, 0, 0, 'h01);
        idle(LAT);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("mis_claim", claim_id_o, 1);
        cyc(0, 0, 1, 3, 2, 'h01);
        idle(LAT);
        chk("mis_claim_kept", claim_id_o, 1);
        chk("mis_meip", meip_o, 0);
        cyc(0, 0, 1, 3, 1, 0);
        cyc(0, 0, 1, 1, 'hFF, 0);
        idle(LAT + 1);

        // Edge coincident with write-1-to-clear: set wins.
        cyc(0, 0, 0, 0, 0, 'h08);
        idle(LAT + 1);
        for (int i = 0; i < LAT; i++) cyc(0, 0, (i == LAT - 1), 1, 'h08, 'h08);
        cyc(0, 0, 0, 1, 0, 0);
        idle(1);
        chk("w1c_set_wins", rdata_o, 'h08);
        cyc(0, 0, 1, 1, 'hFF, 0);
        idle(LAT + 1);

        // Reset mid-service.
        cyc(0, 0, 1, 0, 'hFF, 0);
        cyc(0, 0, 0, 0, 0, 'h08);
        idle(LAT);
        cyc(0, 1, 0, 0, 0, 0);
        idle(1);
        chk("svc_claim", claim_id_o, 4);
        cyc(1, 1, 1, 0, 'hFF, 'hFF);
        idle(1);
        chk("mid_rst_claim", claim_id_o, 0);
        chk("mid_rst_meip", meip_o, 0);
        chk("mid_rst_rdata", rdata_o, 0);
        cyc(0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0);
        chk("mid_rst_en", rdata_o, 0);
        idle(1);
        chk("mid_rst_pend", rdata_o, 0);

        // Randomized traffic.
        src_lvl = 0;
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            ack = ($urandom_range(0, 3) == 0);
            wr  = ($urandom_range(0, 2) == 0);
            a   = $urandom_range(0, 3);
            wd  = $urandom;
            if (a == 3) wd = $urandom_range(0, NUM + 1);
            if (a == 0 && $urandom_range(0, 1) == 1) wd = FULL;
            if (wr && a == 3 && !m_insvc) ack = 0;
            src_lvl = src_lvl ^ ($urandom & $urandom & FULL);
            cyc(rst, ack[0], wr[0], a, wd, src_lvl);
        end
        idle(2);
        @(negedge clk_i);
        chk("sb_drain", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
